// File: rtl/pipe_alu_pkg.sv
// Shared constants and types for the pipelined ALU scheduler slice.
// Holds the stage count, default widths and requester indices.
package pipe_alu_pkg;

   localparam int unsigned STAGES    = 3;
   localparam int unsigned DEF_N     = 10;
   localparam int unsigned DEF_TAG_W = 1;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_idx_e;

endpackage : pipe_alu_pkg

// File: rtl/pipe_alu_sched_if.sv
// Operand-request and result handshake bundle for pipe_alu_sched.
// master = producers/consumer side, slave = scheduler side.
interface pipe_alu_sched_if
   import pipe_alu_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned TAG_W = DEF_TAG_W
);

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [N-1:0]     req0_a, req0_b, req0_c, req0_d;
   logic [N-1:0]     req1_a, req1_b, req1_c, req1_d;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_f;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   modport master (
      output req_valid, req0_a, req0_b, req0_c, req0_d,
             req1_a, req1_b, req1_c, req1_d, out_ready,
      input  req_ready, out_valid, out_f, out_tag, busy
   );

   modport slave (
      input  req_valid, req0_a, req0_b, req0_c, req0_d,
             req1_a, req1_b, req1_c, req1_d, out_ready,
      output req_ready, out_valid, out_f, out_tag, busy
   );

endinterface : pipe_alu_sched_if

// File: rtl/pipe_alu_core.sv
// Three-stage F=((A+B)+(C-D))*D datapath with valid/tag sideband.
// All stages share one enable; arithmetic wraps modulo 2^N.
module pipe_alu_core
   import pipe_alu_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned TAG_W = DEF_TAG_W
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             en,
   input  logic             in_v,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [N-1:0]     in_c,
   input  logic [N-1:0]     in_d,
   output logic             out_v,
   output logic [N-1:0]     out_f,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   logic [STAGES-1:0] vld;
   logic [TAG_W-1:0]  tag_q [STAGES];
   logic [N-1:0]      x1, x2, d1;
   logic [N-1:0]      x3, d2;
   logic [N-1:0]      f3;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vld <= '0;
         x1  <= '0;
         x2  <= '0;
         d1  <= '0;
         x3  <= '0;
         d2  <= '0;
         f3  <= '0;
         for (int unsigned i = 0; i < STAGES; i++) tag_q[i] <= '0;
      end else if (en) begin
         vld <= {vld[STAGES-2:0], in_v};
         x1  <= in_a + in_b;
         x2  <= in_c - in_d;
         d1  <= in_d;
         x3  <= x1 + x2;
         d2  <= d1;
         // N-bit context keeps only the low half of the full product
         f3  <= x3 * d2;
         tag_q[0] <= in_tag;
         for (int unsigned i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign out_v   = vld[STAGES-1];
   assign out_f   = f3;
   assign out_tag = tag_q[STAGES-1];
   assign busy    = |vld;

endmodule : pipe_alu_core

// File: rtl/pipe_alu_sched.sv
// Round-robin two-requester scheduler in front of pipe_alu_core.
// Output backpressure freezes the entire pipe and blocks new issue.
module pipe_alu_sched
   import pipe_alu_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned TAG_W = DEF_TAG_W
) (
   input  logic             Clk,
   input  logic             Rst_n,
   pipe_alu_sched_if.slave  bus
);

   req_idx_e         ptr;
   req_idx_e         grant_idx;
   logic [1:0]       grant;
   logic             any_req;
   logic             stall;
   logic             accept;
   logic             v3;
   logic [N-1:0]     op_a, op_b, op_c, op_d;
   logic [TAG_W-1:0] issue_tag;

   assign stall   = v3 & ~bus.out_ready;
   assign any_req = |bus.req_valid;
   assign accept  = any_req & ~stall;

   always_comb begin
      grant_idx = REQ0;
      unique case (bus.req_valid)
         2'b10:   grant_idx = REQ1;
         2'b11:   grant_idx = ptr;
         default: grant_idx = REQ0;
      endcase
      grant            = '0;
      grant[grant_idx] = any_req;
   end

   assign bus.req_ready = grant & {2{~stall}};

   always_comb begin
      if (grant_idx == REQ1) begin
         op_a = bus.req1_a;
         op_b = bus.req1_b;
         op_c = bus.req1_c;
         op_d = bus.req1_d;
      end else begin
         op_a = bus.req0_a;
         op_b = bus.req0_b;
         op_c = bus.req0_c;
         op_d = bus.req0_d;
      end
   end

   assign issue_tag = TAG_W'(grant_idx);

   // Pointer favours the other requester after every accepted transfer.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr <= REQ0;
      end else if (accept) begin
         ptr <= (grant_idx == REQ0) ? REQ1 : REQ0;
      end
   end

   pipe_alu_core #(
      .N     (N),
      .TAG_W (TAG_W)
   ) u_core (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .en      (~stall),
      .in_v    (any_req),
      .in_tag  (issue_tag),
      .in_a    (op_a),
      .in_b    (op_b),
      .in_c    (op_c),
      .in_d    (op_d),
      .out_v   (v3),
      .out_f   (bus.out_f),
      .out_tag (bus.out_tag),
      .busy    (bus.busy)
   );

   assign bus.out_valid = v3;

endmodule : pipe_alu_sched
